drm_burst_reader: RTL

//   Read-side client for the 64x8192 simple dual-port DRM (1-cycle read latency, no output reg).

---
 rtl/drm_burst_reader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/drm_burst_reader.sv
// Burst read client for the 64x8192 DRM: request -> per-beat RAM reads -> valid/ready response stream.
// Latency: accept edge k -> rsp_valid at cycle k+3 (k+4 with DRM_RD_OUTPUT_REG_EN, RAM output register on).
// Backpressure: credits cover FIFO plus in-flight reads, so a stalled rsp_ready freezes issue without loss.

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic                   rd_vld,
    input  logic                   rd_rdy,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             full;

    assign full   = (count == (AW+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign pop    = rd_vld & rd_rdy;
    assign push   = wr_vld & (!full | pop);
    assign rd_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module drm_burst_reader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  busy
);
`ifdef DRM_RD_OUTPUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } rsp_ent_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [RD_LAT-1:0]     tag_vld;
    logic [RD_LAT-1:0]     tag_last;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         inflight;
    logic [CW:0]           occupancy;
    logic [CW:0]           credit;
    logic                  issue;
    logic                  issue_last;
    logic                  accept;
    logic                  pop;
    logic                  fifo_vld;
    rsp_ent_t              wr_ent;
    rsp_ent_t              rd_ent;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(tag_vld[i]);
        end
    end

    // Credits free up one cycle after a pop; this conservatism is what keeps FIFO_DEPTH >= latency+2 sufficient.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit    = (CW+1)'(FIFO_DEPTH) - occupancy;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (credit != '0) begin
                    issue = 1'b1;
                    if (beat_cnt == '0) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && rd_ent.last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept     = req_valid & req_ready;
    assign issue_last = issue & (beat_cnt == '0);

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state    <= S_IDLE;
            addr_cnt <= '0;
            beat_cnt <= '0;
            tag_vld  <= '0;
            tag_last <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_cnt <= req_addr;
                beat_cnt <= req_len;
            end else if (issue) begin
                addr_cnt <= addr_cnt + 1'b1;
                beat_cnt <= beat_cnt - 1'b1;
            end
            tag_vld[0]  <= issue;
            tag_last[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

    // The address counter itself drives the RAM so the first read goes out the cycle after accept.
    assign ram_rd_addr = addr_cnt;

    assign wr_ent.last = tag_last[RD_LAT-1];
    assign wr_ent.data = ram_rd_data;

    sync_fifo #(
        .WIDTH ($bits(rsp_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk    (rd_clk),
        .rst    (rd_rst),
        .wr_vld (tag_vld[RD_LAT-1]),
        .wr_dat (wr_ent),
        .rd_vld (fifo_vld),
        .rd_rdy (rsp_ready),
        .rd_dat (rd_ent),
        .count  (fifo_count)
    );

    assign pop       = fifo_vld & rsp_ready;
    assign rsp_valid = fifo_vld;
    assign rsp_data  = rd_ent.data;
    assign rsp_last  = fifo_vld & rd_ent.last;
    assign busy      = (state != S_IDLE);

    a_no_overcommit: assert property (@(posedge rd_clk) disable iff (rd_rst)
        occupancy <= (CW+1)'(FIFO_DEPTH));
endmodule
